// File: rtl/imem_loader.sv
// imem_loader: streams 32-bit words into the byte-wide, big-endian
// instruction store, one byte write per cycle at incrementing addresses.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start          begin a load session (sampled in IDLE only)
//   base_addr      first byte address of the session, sampled with start
//   word_valid     word_data/word_last valid
//   word_ready     loader accepts a word this cycle (ACCEPT state)
//   word_data      instruction word, [0:7] = MS byte = lowest address
//   word_last      final word of the session
//   mem_we         registered byte write strobe
//   mem_addr       byte write address (held when mem_we=0)
//   mem_wdata      byte write data (held when mem_we=0)
//   busy           session in progress (state != IDLE)
//   done           one-cycle pulse while in FIN
//   error          sticky until next start: misaligned base or overflow
//   checksum       mod-256 sum of the bytes written this session
//                  (present only with IMEM_LOADER_CHECKSUM_EN defined)
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN

module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_B = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [0:31]       word_data,
  input  logic              word_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [0:7]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [0:7]        checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    FIN
  } state_t;

  // The pointer carries one extra bit so that running past the top
  // of memory stays visible instead of silently wrapping to 0.
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'((2 ** ADDR_W) - WORD_B);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [1:0] LAST_IDX = 2'(WORD_B - 1);

  state_t              state_q;
  logic [ADDR_W:0]     ptr_q;
  logic [1:0]          cnt_q;
  logic [0:31]         word_q;
  logic                last_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [0:7]          wdata_q;
  logic                done_q;
  logic                err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [0:7]          sum_q;
`endif

  function automatic logic [0:7] byte_sel(
    input logic [0:31] w,
    input logic [1:0]  i
  );
    return w[{i, 3'b000} +: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            err_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q <= '0;
`endif
            if (base_addr[1:0] != 2'b00) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              ptr_q   <= {1'b0, base_addr};
              state_q <= ACCEPT;
            end
          end
        end
        ACCEPT: begin
          if (word_valid) begin
            word_q <= word_data;
            last_q <= word_last;
            if (ptr_q > LIMIT) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              // Byte 0 goes out on the cycle right after the handshake.
              we_q    <= 1'b1;
              addr_q  <= ptr_q[ADDR_W-1:0];
              wdata_q <= word_data[0:7];
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum_q   <= sum_q + word_data[0:7];
`endif
              ptr_q   <= ptr_q + ONE;
              cnt_q   <= 2'd0;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          // cnt_q is the byte currently on the write port.
          if (cnt_q != LAST_IDX) begin
            we_q    <= 1'b1;
            addr_q  <= ptr_q[ADDR_W-1:0];
            wdata_q <= byte_sel(word_q, cnt_q + 2'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_q + byte_sel(word_q, cnt_q + 2'd1);
`endif
            ptr_q   <= ptr_q + ONE;
            cnt_q   <= cnt_q + 2'd1;
          end else if (last_q) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            state_q <= ACCEPT;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign word_ready = (state_q == ACCEPT);
  assign busy       = (state_q != IDLE);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign done       = done_q;
  assign error      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum   = sum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with a byte-memory
// model on the write port and immediate-assertion checks.

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [0:31] word_data = '0;
  logic        word_last = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [0:7]  mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [0:7]  checksum;
`endif

  int total = 0;
  int bad = 0;

  logic [7:0] mem [256];
  logic       clr = 1'b1;
  int         we_cnt = 0;
  int         done_cnt = 0;
  int         we0, dn0, rc;
  int         rdy_at [4];
  logic [31:0] wv [3];

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_last  (word_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_we) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic l);
    word_valid = 1'b1;
    word_data  = w;
    word_last  = l;
    for (int n = 0; n < 20 && !word_ready; n++) tick;
    chk("ready_wait", word_ready, 1);
    tick;
    word_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 30 && !done; n++) tick;
    chk(tag, done, 1);
  endtask

  initial begin
    // reset state
    tick;
    tick;
    clr = 1'b0;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ready", word_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    rst = 1'b0;
    tick;

    // two-word session at base 0
    we0 = we_cnt;
    dn0 = done_cnt;
    start = 1'b1;
    base_addr = 8'h00;
    tick;
    start = 1'b0;
    chk("t1_ready", word_ready, 1);
    chk("t1_busy", busy, 1);
    send(32'h8C010004, 1'b0);
    chk("t1_first_we", mem_we, 1);
    chk("t1_first_addr", mem_addr, 0);
    chk("t1_first_byte", mem_wdata, 32'h8C);
    chk("t1_ready_low", word_ready, 0);
    send(32'h00221820, 1'b1);
    wait_done("t1_done");
    tick;
    chk("t1_idle", busy, 0);
    chk("t1_m0", mem[0], 32'h8C);
    chk("t1_m1", mem[1], 32'h01);
    chk("t1_m2", mem[2], 32'h00);
    chk("t1_m3", mem[3], 32'h04);
    chk("t1_m4", mem[4], 32'h00);
    chk("t1_m5", mem[5], 32'h22);
    chk("t1_m6", mem[6], 32'h18);
    chk("t1_m7", mem[7], 32'h20);
    chk("t1_we_cnt", we_cnt - we0, 8);
    chk("t1_done_cnt", done_cnt - dn0, 1);
    chk("t1_err", error, 0);

    // misaligned base
    we0 = we_cnt;
    start = 1'b1;
    base_addr = 8'h02;
    word_valid = 1'b1;
    word_data = 32'h12345678;
    chk("t2_ready0", word_ready, 0);
    tick;
    start = 1'b0;
    chk("t2_done", done, 1);
    chk("t2_err", error, 1);
    chk("t2_ready1", word_ready, 0);
    tick;
    chk("t2_done_off", done, 0);
    chk("t2_ready2", word_ready, 0);
    chk("t2_busy", busy, 0);
    chk("t2_err_hold", error, 1);
    chk("t2_no_we", we_cnt - we0, 0);
    word_valid = 1'b0;

    // top-of-memory boundary then overflow
    we0 = we_cnt;
    start = 1'b1;
    base_addr = 8'hFC;
    tick;
    start = 1'b0;
    chk("t3_err_clr", error, 0);
    send(32'h11223344, 1'b0);
    send(32'hAABBCCDD, 1'b1);
    chk("t3_done", done, 1);
    chk("t3_err", error, 1);
    chk("t3_no_we", mem_we, 0);
    tick;
    chk("t3_busy", busy, 0);
    chk("t3_err_hold", error, 1);
    chk("t3_we_cnt", we_cnt - we0, 4);
    chk("t3_mFC", mem[8'hFC], 32'h11);
    chk("t3_mFD", mem[8'hFD], 32'h22);
    chk("t3_mFE", mem[8'hFE], 32'h33);
    chk("t3_mFF", mem[8'hFF], 32'h44);
    chk("t3_no_wrap", mem[0], 32'h8C);

    // reset in the second write cycle
    start = 1'b1;
    base_addr = 8'h20;
    tick;
    start = 1'b0;
    chk("t5_err_clr", error, 0);
    send(32'hCAFEF00D, 1'b1);
    tick;
    chk("t5_addr21", mem_addr, 32'h21);
    rst = 1'b1;
    tick;
    chk("t5_we", mem_we, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err", error, 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_m20", mem[8'h20], 32'hCA);
    chk("t5_m21", mem[8'h21], 32'hFE);
    chk("t5_m22", mem[8'h22], 32'h00);
    rst = 1'b0;
    tick;
    start = 1'b1;
    base_addr = 8'h40;
    tick;
    start = 1'b0;
    send(32'h0BADC0DE, 1'b1);
    wait_done("t5_done");
    tick;
    chk("t5_m40", mem[8'h40], 32'h0B);
    chk("t5_m43", mem[8'h43], 32'hDE);
    chk("t5_err2", error, 0);

    // word_valid held high across a 3-word session
    wv[0] = 32'hDEADBEEF;
    wv[1] = 32'h01234567;
    wv[2] = 32'h89ABCDEF;
    we0 = we_cnt;
    start = 1'b1;
    base_addr = 8'h10;
    tick;
    start = 1'b0;
    rc = 0;
    word_valid = 1'b1;
    word_data = wv[0];
    word_last = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (word_ready) begin
        if (rc < 4) rdy_at[rc] = c;
        rc++;
        tick;
        if (rc < 3) begin
          word_data = wv[rc];
          word_last = (rc == 2);
        end
      end else begin
        tick;
      end
    end
    chk("t4_done", done, 1);
    word_valid = 1'b0;
    tick;
    chk("t4_rdy_cnt", rc, 3);
    chk("t4_gap1", rdy_at[1] - rdy_at[0], 5);
    chk("t4_gap2", rdy_at[2] - rdy_at[1], 5);
    chk("t4_we_cnt", we_cnt - we0, 12);
    chk("t4_m10", mem[8'h10], 32'hDE);
    chk("t4_m13", mem[8'h13], 32'hEF);
    chk("t4_m14", mem[8'h14], 32'h01);
    chk("t4_m17", mem[8'h17], 32'h67);
    chk("t4_m18", mem[8'h18], 32'h89);
    chk("t4_m1B", mem[8'h1B], 32'hEF);
    chk("t4_idle", busy, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    start = 1'b1;
    base_addr = 8'h80;
    tick;
    start = 1'b0;
    chk("cs_clear", checksum, 0);
    send(32'h01020304, 1'b0);
    send(32'hFFFFFFFF, 1'b1);
    wait_done("cs_done");
    chk("cs_fin", checksum, 32'h06);
    tick;
    tick;
    chk("cs_hold", checksum, 32'h06);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
